hazard_stall_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage core. Generates per-stage write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Handles four conditions: load-use stalls (cases the ALU forwarding paths cannot cover), taken-branch flushes, multi-cycle multiply occupancy of EX, and data-memory wait states.
- Keeps a saturating count of stall cycles for performance monitoring.

---
 rtl/hazard_stall_controller.sv | 153 +++++++++++++++
 tb/tb_hazard_stall_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage core: per-stage write-enable and
// flush generation for load-use, branch, multiply-occupancy and data-memory wait hazards.
module hazard_stall_controller #(
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs1,
    input  logic [4:0]       ID_Rs2,
    input  logic             ID_UsesRs1,
    input  logic             ID_UsesRs2,
    input  logic [4:0]       EX_Rd,
    input  logic             EX_MemRead,
    input  logic             EX_BranchTaken,
    input  logic             EX_MulStart,
    input  logic             MEM_MemReq,
    input  logic             DMem_Ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic             EX_MEM_Flush,
    output logic             MEM_WB_Write,
    output logic             MEM_WB_Flush,
    output logic [CNT_W-1:0] StallCount
);

    localparam int                   MUL_CNT_W   = $clog2(MUL_LATENCY) + 1;
    localparam bit                   MUL_STALLS  = (MUL_LATENCY > 1);
    localparam int                   MUL_LOAD_I  = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;
    localparam logic [MUL_CNT_W-1:0] MUL_LOAD    = MUL_CNT_W'(MUL_LOAD_I);
    localparam logic [CNT_W-1:0]     STALL_MAX   = '1;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } memState_t;

    memState_t             memState;
    memState_t             memStateNext;
    logic                  mulActive;
    logic                  mulActiveNext;
    logic [MUL_CNT_W-1:0]  mulCnt;
    logic [MUL_CNT_W-1:0]  mulCntNext;

    logic                  freeze;
    logic                  mulLaunch;
    logic                  mulBusy;
    logic                  rs1Hit;
    logic                  rs2Hit;
    logic                  loadUse;

    assign freeze    = MEM_MemReq && !DMem_Ready;
    assign mulLaunch = EX_MulStart && !mulActive && MUL_STALLS;
    assign mulBusy   = mulLaunch || (mulActive && (mulCnt != '0));
    assign rs1Hit    = ID_UsesRs1 && (ID_Rs1 == EX_Rd);
    assign rs2Hit    = ID_UsesRs2 && (ID_Rs2 == EX_Rd);
    assign loadUse   = EX_MemRead && (EX_Rd != 5'd0) && (rs1Hit || rs2Hit);

    // State registers: memory-wait status, multiply occupancy and the stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            memState   <= RUN;
            mulActive  <= 1'b0;
            mulCnt     <= '0;
            StallCount <= '0;
        end else begin
            memState  <= memStateNext;
            mulActive <= mulActiveNext;
            mulCnt    <= mulCntNext;
            if (!PC_Write && (StallCount != STALL_MAX)) begin
                StallCount <= StallCount + 1'b1;
            end
        end
    end

    // mem_state is status only; the stall decision always uses the live freeze term.
    always_comb begin
        memStateNext = memState;
        case (memState)
            RUN: begin
                if (freeze) begin
                    memStateNext = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (!freeze) begin
                    memStateNext = RUN;
                end
            end
            default: memStateNext = RUN;
        endcase
    end

    // The multiplier keeps counting through frozen cycles, but the multiply can only
    // leave EX on an unfrozen cycle.
    always_comb begin
        mulActiveNext = mulActive;
        mulCntNext    = mulCnt;
        if (mulLaunch) begin
            mulActiveNext = 1'b1;
            mulCntNext    = MUL_LOAD;
        end else if (mulActive) begin
            if (mulCnt != '0) begin
                mulCntNext = mulCnt - 1'b1;
            end else if (!freeze) begin
                mulActiveNext = 1'b0;
            end
        end
    end

    // Hazard priority: memory freeze, multiply occupancy, taken branch, load-use.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Write  = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Write = 1'b1;
        EX_MEM_Flush = 1'b0;
        MEM_WB_Write = 1'b1;
        MEM_WB_Flush = 1'b0;
        if (reset) begin
            PC_Write     = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            MEM_WB_Flush = 1'b1;
        end else if (freeze) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Flush = 1'b1;
        end else if (mulBusy) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
        end else if (EX_BranchTaken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
        end else if (loadUse) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Flush  = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed hazard scenarios followed by
// randomized traffic, all compared against a rule-level reference model.
module tb_hazard_stall_controller;

    localparam int MUL_LATENCY = 3;
    localparam int CNT_W       = 5;
    localparam int STALL_MAX   = (1 << CNT_W) - 1;

    localparam logic [8:0] CTRL_RESET  = 9'b011111111;
    localparam logic [8:0] CTRL_FREE   = 9'b110101010;
    localparam logic [8:0] CTRL_LDUSE  = 9'b000111010;
    localparam logic [8:0] CTRL_BRANCH = 9'b111111010;
    localparam logic [8:0] CTRL_MUL    = 9'b000001110;
    localparam logic [8:0] CTRL_FREEZE = 9'b000000011;

    logic             clk;
    logic             reset;
    logic [4:0]       ID_Rs1;
    logic [4:0]       ID_Rs2;
    logic             ID_UsesRs1;
    logic             ID_UsesRs2;
    logic [4:0]       EX_Rd;
    logic             EX_MemRead;
    logic             EX_BranchTaken;
    logic             EX_MulStart;
    logic             MEM_MemReq;
    logic             DMem_Ready;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Write;
    logic             ID_EX_Flush;
    logic             EX_MEM_Write;
    logic             EX_MEM_Flush;
    logic             MEM_WB_Write;
    logic             MEM_WB_Flush;
    logic [CNT_W-1:0] StallCount;

    int vectors;
    int miscompares;

    // Reference model state: is a multiply in EX, how many cycles since it started,
    // and the stall count as a plain integer.
    bit   mMulInEx;
    int   mMulAge;
    int   mStalls;
    logic [8:0] lastCtrl;

    hazard_stall_controller #(
        .MUL_LATENCY(MUL_LATENCY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ID_Rs1        (ID_Rs1),
        .ID_Rs2        (ID_Rs2),
        .ID_UsesRs1    (ID_UsesRs1),
        .ID_UsesRs2    (ID_UsesRs2),
        .EX_Rd         (EX_Rd),
        .EX_MemRead    (EX_MemRead),
        .EX_BranchTaken(EX_BranchTaken),
        .EX_MulStart   (EX_MulStart),
        .MEM_MemReq    (MEM_MemReq),
        .DMem_Ready    (DMem_Ready),
        .PC_Write      (PC_Write),
        .IF_ID_Write   (IF_ID_Write),
        .IF_ID_Flush   (IF_ID_Flush),
        .ID_EX_Write   (ID_EX_Write),
        .ID_EX_Flush   (ID_EX_Flush),
        .EX_MEM_Write  (EX_MEM_Write),
        .EX_MEM_Flush  (EX_MEM_Flush),
        .MEM_WB_Write  (MEM_WB_Write),
        .MEM_WB_Flush  (MEM_WB_Flush),
        .StallCount    (StallCount)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare DUT outputs with the model mid-cycle; returns whether the model stalls the PC.
    task automatic checkOutput(input string tag, output bit pcStall, output bit freeze);
        logic [8:0] expCtrl;
        logic [8:0] obsCtrl;
        bit loadUse;
        bit mulBusy;
        freeze  = MEM_MemReq && !DMem_Ready;
        loadUse = EX_MemRead && (EX_Rd != 0) &&
                  ((ID_UsesRs1 && ID_Rs1 == EX_Rd) || (ID_UsesRs2 && ID_Rs2 == EX_Rd));
        mulBusy = mMulInEx ? (mMulAge < MUL_LATENCY - 1)
                           : (EX_MulStart && MUL_LATENCY > 1);
        if (reset)               expCtrl = CTRL_RESET;
        else if (freeze)         expCtrl = CTRL_FREEZE;
        else if (mulBusy)        expCtrl = CTRL_MUL;
        else if (EX_BranchTaken) expCtrl = CTRL_BRANCH;
        else if (loadUse)        expCtrl = CTRL_LDUSE;
        else                     expCtrl = CTRL_FREE;
        pcStall = !reset && !expCtrl[8];
        obsCtrl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
                   EX_MEM_Write, EX_MEM_Flush, MEM_WB_Write, MEM_WB_Flush};
        lastCtrl = obsCtrl;
        checkValue({tag, ".ctrl"}, 32'(obsCtrl), 32'(expCtrl));
        if (!reset) begin
            checkValue({tag, ".count"}, 32'(StallCount), 32'(mStalls));
        end
    endtask

    task automatic applyStimulus(input string tag, input bit rst,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input bit uses1, input bit uses2,
                                 input logic [4:0] rd, input bit memRead, input bit branch,
                                 input bit mulStart, input bit memReq, input bit ready);
        bit pcStall;
        bit freeze;
        reset          = rst;
        ID_Rs1         = rs1;
        ID_Rs2         = rs2;
        ID_UsesRs1     = uses1;
        ID_UsesRs2     = uses2;
        EX_Rd          = rd;
        EX_MemRead     = memRead;
        EX_BranchTaken = branch;
        EX_MulStart    = mulStart;
        MEM_MemReq     = memReq;
        DMem_Ready     = ready;
        @(negedge clk);
        checkOutput(tag, pcStall, freeze);
        @(posedge clk);
        if (rst) begin
            mMulInEx = 0;
            mMulAge  = 0;
            mStalls  = 0;
        end else begin
            if (pcStall && mStalls < STALL_MAX) mStalls++;
            if (!mMulInEx) begin
                if (mulStart && MUL_LATENCY > 1) begin
                    mMulInEx = 1;
                    mMulAge  = 1;
                end
            end else if (mMulAge < MUL_LATENCY - 1) begin
                mMulAge++;
            end else if (!freeze) begin
                mMulInEx = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(tag, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        clk         = 0;
        vectors     = 0;
        miscompares = 0;
        mMulInEx    = 0;
        mMulAge     = 0;
        mStalls     = 0;

        // Reset held two cycles.
        applyStimulus("reset0", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        checkValue("resetCtrl", 32'(lastCtrl), 32'(CTRL_RESET));
        applyStimulus("reset1", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        idle("afterReset", 1);
        checkValue("afterResetCtrl", 32'(lastCtrl), 32'(CTRL_FREE));
        checkValue("afterResetCount", 32'(StallCount), 32'd0);

        // Load-use on Rs2, then the same pattern targeting x0.
        applyStimulus("loadUse", 0, 5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 0);
        checkValue("loadUseCtrl", 32'(lastCtrl), 32'(CTRL_LDUSE));
        idle("postLoad", 1);
        checkValue("loadUseCount", 32'(StallCount), 32'd1);
        applyStimulus("loadX0", 0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 0);
        checkValue("loadX0Ctrl", 32'(lastCtrl), 32'(CTRL_FREE));

        // Taken branch wins over a simultaneous load-use.
        applyStimulus("branch", 0, 5'd7, 5'd0, 1, 0, 5'd7, 1, 1, 0, 0, 0);
        checkValue("branchCtrl", 32'(lastCtrl), 32'(CTRL_BRANCH));
        idle("postBranch", 1);
        checkValue("branchCount", 32'(StallCount), 32'd1);

        // Multiply: two stall cycles then the third is free.
        applyStimulus("mul0", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
        checkValue("mul0Ctrl", 32'(lastCtrl), 32'(CTRL_MUL));
        applyStimulus("mul1", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
        checkValue("mul1Ctrl", 32'(lastCtrl), 32'(CTRL_MUL));
        applyStimulus("mul2", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
        checkValue("mul2Ctrl", 32'(lastCtrl), 32'(CTRL_FREE));
        idle("postMul", 1);
        checkValue("mulCount", 32'(StallCount), 32'd3);

        // Data-memory wait of three cycles, release cycle free.
        for (int i = 0; i < 3; i++) begin
            applyStimulus("memWait", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
            checkValue("memWaitCtrl", 32'(lastCtrl), 32'(CTRL_FREEZE));
        end
        applyStimulus("memDone", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1);
        checkValue("memDoneCtrl", 32'(lastCtrl), 32'(CTRL_FREE));
        idle("postMem", 1);
        checkValue("memCount", 32'(StallCount), 32'd6);

        // Multiply whose countdown expires under a four-cycle freeze.
        applyStimulus("mulF0", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("mulFreeze", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0);
        end
        applyStimulus("mulUnfreeze", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
        checkValue("mulUnfreezeCtrl", 32'(lastCtrl), 32'(CTRL_FREE));
        idle("postMulFreeze", 1);
        checkValue("mulFreezeCount", 32'(StallCount), 32'd11);

        // Reset in the middle of a frozen multiply clears everything.
        applyStimulus("mulR0", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
        applyStimulus("mulR1", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0);
        applyStimulus("midReset", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0);
        idle("postMidReset", 1);
        checkValue("midResetCtrl", 32'(lastCtrl), 32'(CTRL_FREE));
        checkValue("midResetCount", 32'(StallCount), 32'd0);

        // Saturation of the stall counter.
        for (int i = 0; i < STALL_MAX + 6; i++) begin
            applyStimulus("saturate", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        end
        idle("postSaturate", 1);
        checkValue("saturateCount", 32'(StallCount), 32'(STALL_MAX));

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus("random",
                          ($urandom_range(0, 49) == 0),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
